// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive/transmit FSM state encoding, frame width, default oversample.
// Also provides a counter-width helper so rx and tx size their tick counters the same way.
// Imported by spart_rx, spart_rx_if and (later) spart_tx.
package spart_pkg;

  localparam int SPART_DATA_BITS  = 8;
  localparam int SPART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Width of a counter that must hold 0..n-1 (at least 1 bit).
  function automatic int spart_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spart_rx_if.sv
// Receive-stage bus: baud tick and serial line in, byte/rda (and optional ferr) out.
// Ports: enable, rxd, clr_rda driven by master; rx_buffer, rda, ferr driven by slave (spart_rx).
// ferr exists only when SPART_RX_FERR_EN is defined.
interface spart_rx_if;
  import spart_pkg::*;

  logic                       enable;
  logic                       rxd;
  logic                       clr_rda;
  logic [SPART_DATA_BITS-1:0] rx_buffer;
  logic                       rda;

`ifdef SPART_RX_FERR_EN
  logic                       ferr;

  modport master (output enable, rxd, clr_rda, input  rx_buffer, rda, ferr);
  modport slave  (input  enable, rxd, clr_rda, output rx_buffer, rda, ferr);
`else
  modport master (output enable, rxd, clr_rda, input  rx_buffer, rda);
  modport slave  (input  enable, rxd, clr_rda, output rx_buffer, rda);
`endif

endinterface

// File: rtl/spart_sync.sv
// Metastability synchroniser: SYNC_STAGES flop chain, resets to 1 (idle level of a serial line).
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out). Latency SYNC_STAGES clks.
// No backpressure; samples every clk.
module spart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: oversampled UART deserialiser (8N1, LSB first) feeding the bus interface.
// Ports: clk, rst (sync, active-high), rx (spart_rx_if.slave: enable, rxd, clr_rda -> rx_buffer, rda[, ferr]).
// Optional SPART_RX_FERR_EN: bad stop bit drops the byte and pulses ferr for one clk.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE  = SPART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spart_rx_if.slave   rx
);

  localparam int TW = spart_cnt_w(OVERSAMPLE);
  localparam int BW = spart_cnt_w(SPART_DATA_BITS);

  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SPART_DATA_BITS - 1);

  logic                       rxd_s;

  rx_state_t                  state, state_nxt;
  logic [TW-1:0]              tick_cnt, tick_nxt;
  logic [BW-1:0]              bit_cnt, bit_nxt;
  logic [SPART_DATA_BITS-1:0] sr, sr_nxt;
  logic [SPART_DATA_BITS-1:0] rx_buffer_q;
  logic                       rda_q;
  logic                       load;

`ifdef SPART_RX_FERR_EN
  logic                       frame_err;
  logic                       ferr_q;
`endif

  spart_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.rxd),
    .q   (rxd_s)
  );

  // Next-state / datapath strobes. Everything holds unless this clk carries a baud tick.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    sr_nxt    = sr;
    load      = 1'b0;
`ifdef SPART_RX_FERR_EN
    frame_err = 1'b0;
`endif
    if (rx.enable) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          // Re-check the line half a bit in; a high here was a glitch.
          if (tick_cnt == HALF_M1) begin
            tick_nxt = '0;
            bit_nxt  = '0;
            state_nxt = rxd_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_M1) begin
            tick_nxt = '0;
            sr_nxt   = {rxd_s, sr[SPART_DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_M1) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
`ifdef SPART_RX_FERR_EN
            load      = rxd_s;
            frame_err = !rxd_s;
`else
            // Stop level is not checked in this build; every frame is delivered.
            load      = 1'b1;
`endif
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          tick_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      rx_buffer_q <= '0;
      rda_q       <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      sr       <= sr_nxt;
      // A load on the same clk as clr_rda keeps rda set: the fresh byte must not be lost.
      // A load while rda is already set overwrites the unread byte (overrun).
      if (load) begin
        rx_buffer_q <= sr;
        rda_q       <= 1'b1;
      end else if (rx.clr_rda) begin
        rda_q <= 1'b0;
      end
    end
  end

`ifdef SPART_RX_FERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= frame_err;
    end
  end

  assign rx.ferr = ferr_q;
`endif

  assign rx.rx_buffer = rx_buffer_q;
  assign rx.rda       = rda_q;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: directed frames plus randomized frames/glitches/clears,
// checked against a frame-level model (byte lands 155 clks after the start edge is driven).
// Works with or without SPART_RX_FERR_EN.
module tb_spart_rx;
  import spart_pkg::*;

`ifdef SPART_RX_FERR_EN
  localparam bit FERR_EN = 1'b1;
`else
  localparam bit FERR_EN = 1'b0;
`endif

  // With enable every clk: start seen 3 edges after drive, load 152 ticks later.
  localparam int LOAD_AT   = 155;
  localparam int FRAME_CLK = 10 * 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spart_rx_if rx_if ();

  spart_rx #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if.slave)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;

  // Reference state: what the bus interface should currently see.
  logic [7:0] m_buf = 8'h00;
  logic       m_rda = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rda"}, 32'(rx_if.rda), 32'(m_rda));
    check({tag, ".buf"}, 32'(rx_if.rx_buffer), 32'(m_buf));
  endtask

  // Line level for clk i of a frame: start, 8 data bits LSB first, stop.
  function automatic logic frame_level(input logic [7:0] b, input logic stop_bit, input int i);
    int slot;
    slot = i / 16;
    if (slot == 0)      return 1'b0;
    else if (slot <= 8) return b[slot-1];
    else                return stop_bit;
  endfunction

  // Sends one frame starting right after the current edge. clr_at >= 0 pulses clr_rda
  // during clk clr_at of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int clr_at);
    bit will_load;
    will_load = stop_bit || !FERR_EN;
    for (int i = 0; i <= FRAME_CLK; i++) begin
      if (i > 0) begin
        step();
        if (clr_at >= 0 && i == clr_at + 1) m_rda = 1'b0;
        if (i == LOAD_AT && will_load) begin
          m_rda = 1'b1;
          m_buf = b;
        end
        if (i == LOAD_AT - 1)                   check_outputs("pre_load");
        if (i == LOAD_AT)                       check_outputs("load");
        if (clr_at >= 0 && i == clr_at + 1)     check_outputs("after_clr");
        if (i == FRAME_CLK)                     check_outputs("frame_end");
`ifdef SPART_RX_FERR_EN
        if (i == LOAD_AT - 1) check("ferr_pre", 32'(rx_if.ferr), 32'd0);
        if (i == LOAD_AT)     check("ferr_pulse", 32'(rx_if.ferr), 32'(!stop_bit));
        if (i == LOAD_AT + 1) check("ferr_end", 32'(rx_if.ferr), 32'd0);
`endif
      end
      if (i < FRAME_CLK) begin
        rx_if.rxd     = frame_level(b, stop_bit, i);
        rx_if.clr_rda = (i == clr_at);
      end else begin
        rx_if.rxd     = 1'b1;
        rx_if.clr_rda = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    rx_if.rxd = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Short low pulse that must be rejected at the mid-start check.
  task automatic glitch(input int len);
    rx_if.rxd = 1'b0;
    for (int i = 0; i < len; i++) step();
    idle(14);
    check_outputs("glitch");
  endtask

  // Line held low: a frame of 0x00 with a low stop bit every 153 clks.
  task automatic break_test();
    for (int i = 0; i <= 310; i++) begin
      if (i > 0) begin
        step();
        if (i == 201) m_rda = 1'b0;
        if ((i == LOAD_AT || i == LOAD_AT + 153) && !FERR_EN) begin
          m_rda = 1'b1;
          m_buf = 8'h00;
        end
        if (i == LOAD_AT || i == LOAD_AT + 153 || i == LOAD_AT + 152 || i == 201)
          check_outputs("break");
`ifdef SPART_RX_FERR_EN
        if (i == LOAD_AT || i == LOAD_AT + 153) check("break_ferr", 32'(rx_if.ferr), 32'd1);
        if (i == LOAD_AT + 1)                   check("break_ferr_end", 32'(rx_if.ferr), 32'd0);
`endif
      end
      rx_if.rxd     = (i == 310);
      rx_if.clr_rda = (i == 200);
    end
    idle(30);
    check_outputs("break_release");
  endtask

  // Reset asserted during data bit 4 of a 0xFF frame.
  task automatic reset_mid_frame();
    for (int i = 0; i <= 86; i++) begin
      if (i > 0) step();
      if (i < 86) rx_if.rxd = frame_level(8'hFF, 1'b1, i);
      if (i == 85) rst = 1'b1;
    end
    m_rda = 1'b0;
    m_buf = 8'h00;
    check_outputs("reset_mid");
`ifdef SPART_RX_FERR_EN
    check("reset_mid.ferr", 32'(rx_if.ferr), 32'd0);
`endif
    rst = 1'b0;
    rx_if.rxd = 1'b1;
    idle(200);
    check_outputs("reset_quiet");
  endtask

  initial begin
    rx_if.enable  = 1'b1;
    rx_if.rxd     = 1'b1;
    rx_if.clr_rda = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_outputs("reset");
`ifdef SPART_RX_FERR_EN
    check("reset.ferr", 32'(rx_if.ferr), 32'd0);
`endif
    rst = 1'b0;
    idle(5);

    // Basic frame, then a clear well after the load.
    send_frame(8'hA5, 1'b1, 158);
    idle(3);
    // Glitch rejected, following frame unaffected.
    glitch(4);
    send_frame(8'h3C, 1'b1, -1);
    // Back-to-back with no clear: overrun overwrite.
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'hEE, 1'b1, -1);
    // Clear on the exact clk of the load.
    send_frame(8'h5A, 1'b1, 154);
    reset_mid_frame();
    send_frame(8'h81, 1'b1, 158);
    // Bad stop bit.
    send_frame(8'h42, 1'b0, -1);
    idle(20);
    send_frame(8'hC7, 1'b1, -1);
    idle(10);
    break_test();
    send_frame(8'h69, 1'b1, -1);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      int         kind;
      int         clr_at;
      logic [7:0] b;
      logic       stop_bit;
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        glitch(int'($urandom_range(1, 6)));
      end else begin
        b        = 8'($urandom);
        stop_bit = ($urandom_range(0, 5) != 0);
        case ($urandom_range(0, 3))
          0:       clr_at = -1;
          1:       clr_at = LOAD_AT - 1;
          2:       clr_at = int'($urandom_range(0, FRAME_CLK - 1));
          default: clr_at = int'($urandom_range(LOAD_AT + 1, FRAME_CLK - 1));
        endcase
        send_frame(b, stop_bit, clr_at);
        if (!stop_bit) idle(int'($urandom_range(4, 10)));
        else           idle(int'($urandom_range(0, 8)));
      end
    end
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
